// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter for register-file write ports.  Also keeps a
//            busy scoreboard with reservation and hazard-check ports.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int REG_WIDTH = 16,
    parameter int NUM_REGS  = 8,
    parameter int REGS_W    = 3,
    parameter int NUM_REQ   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*REGS_W-1:0]    req_rd,
    input  logic [NUM_REQ*REG_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         rsv_valid,
    input  logic [REGS_W-1:0]            rsv_rd,
    output logic                         rsv_ready,
    input  logic [REGS_W-1:0]            chk_rs,
    input  logic [REGS_W-1:0]            chk_rt,
    output logic                         chk_hazard,
    output logic                         wr_en,
    output logic [REGS_W-1:0]            wr_rd,
    output logic [REG_WIDTH-1:0]         wr_data,
    output logic [NUM_REGS-1:0]          busy,
    output logic [7:0]                   conflict_cnt
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_SUM_W = c_PTR_W + 1;
    localparam logic [c_SUM_W-1:0] c_NREQ = c_SUM_W'(NUM_REQ);

    logic [c_PTR_W-1:0]   r_ptr;
    logic                 r_wr_en;
    logic [REGS_W-1:0]    r_wr_rd;
    logic [REG_WIDTH-1:0] r_wr_data;
    logic [NUM_REGS-1:0]  r_busy;
    logic [7:0]           r_cnt;

    logic [NUM_REQ-1:0]   w_rot;
    logic                 w_found;
    logic [c_SUM_W-1:0]   w_sum;
    logic [c_SUM_W-1:0]   w_inc;
    logic [c_PTR_W-1:0]   w_win;
    logic [c_PTR_W-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0]   w_grant;
    logic [REGS_W-1:0]    w_sel_rd;
    logic [REG_WIDTH-1:0] w_sel_data;
    logic                 w_multi;
    logic                 w_rsv_fire;
    logic [NUM_REGS-1:0]  w_busy_nxt;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit of
    // the rotated vector is the winner, mapped back by adding ptr mod NUM_REQ.
    always_comb begin
        w_rot   = NUM_REQ'({req_valid, req_valid} >> r_ptr);
        w_found = 1'b0;
        w_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + c_SUM_W'(k);
            end
        end
        if (w_sum >= c_NREQ) begin
            w_sum = w_sum - c_NREQ;
        end
        w_win   = w_sum[c_PTR_W-1:0];
        w_grant = '0;
        if (w_found) begin
            w_grant[w_win] = 1'b1;
        end
        w_inc = {1'b0, w_win} + c_SUM_W'(1);
        if (w_inc >= c_NREQ) begin
            w_inc = '0;
        end
        w_ptr_nxt = w_inc[c_PTR_W-1:0];
    end

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_rd   = req_rd[i*REGS_W +: REGS_W];
                w_sel_data = req_data[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // Contention means two or more bits set: clearing the lowest leaves some.
    assign w_multi    = |(req_valid & (req_valid - NUM_REQ'(1)));
    assign rsv_ready  = ~r_busy[rsv_rd];
    assign w_rsv_fire = rsv_valid & rsv_ready;

    // Clear first, then set, so a same-edge reservation wins over the write.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_found) begin
            w_busy_nxt[w_sel_rd] = 1'b0;
        end
        if (w_rsv_fire) begin
            w_busy_nxt[rsv_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_rd   <= '0;
            r_wr_data <= '0;
            r_busy    <= '0;
            r_cnt     <= '0;
        end else begin
            r_wr_en <= w_found;
            r_busy  <= w_busy_nxt;
            if (w_found) begin
                r_ptr     <= w_ptr_nxt;
                r_wr_rd   <= w_sel_rd;
                r_wr_data <= w_sel_data;
            end
            if (w_multi && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign req_ready    = w_grant;
    assign chk_hazard   = r_busy[chk_rs] | r_busy[chk_rt];
    assign wr_en        = r_wr_en;
    assign wr_rd        = r_wr_rd;
    assign wr_data      = r_wr_data;
    assign busy         = r_busy;
    assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire
